// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch stage with IF/ID register and response FIFO
// Optional feature macro IF_PERF_EN adds perf_fetch_o/perf_bubble_o counters.
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_ack_i,
  input  logic [31:0] rom_data_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
`ifdef IF_PERF_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_bubble_o
`endif
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0]      buf_pc_q   [BUF_DEPTH];
  logic [31:0]      buf_inst_q [BUF_DEPTH];
  logic [31:0]      id_pc_q, id_pc_d, id_inst_q, id_inst_d;
  logic             id_valid_q, id_valid_d;
  logic             ack_fire, ack_take, push, pop, bypass;
  logic [31:0]      redirect_pc_al;

  always_comb begin
    redirect_pc_al = redirect_pc_i & ~32'h3;
    ack_fire = (state_q == S_REQ) && rom_ack_i;
    ack_take = ack_fire && !drop_q && !redirect_i;
    pop      = !redirect_i && !stall_i && (count_q != '0);
    bypass   = !redirect_i && !stall_i && (count_q == '0) && ack_take;
    push     = ack_take && !bypass;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    if (redirect_i)    fetch_pc_d = redirect_pc_al;
    else if (ack_take) fetch_pc_d = fetch_pc_q + 32'd4;
    else               fetch_pc_d = fetch_pc_q;

    // A request caught mid-flight by a redirect must still complete; its data is thrown away.
    if (redirect_i)    drop_d = (state_q == S_REQ) && !rom_ack_i;
    else if (ack_fire) drop_d = 1'b0;
    else               drop_d = drop_q;

    // Issue only when the eventual response is guaranteed a FIFO slot even if decode stalls.
    state_d = state_q;
    addr_d  = addr_q;
    if ((state_q == S_IDLE) || ack_fire) begin
      if (count_d < CNT_W'(BUF_DEPTH)) begin
        state_d = S_REQ;
        addr_d  = fetch_pc_d;
      end else begin
        state_d = S_IDLE;
      end
    end

    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    if (redirect_i) begin
      id_inst_d  = 32'h0;
      id_valid_d = 1'b0;
    end else if (!stall_i) begin
      if (pop) begin
        id_pc_d    = buf_pc_q[rd_ptr_q];
        id_inst_d  = buf_inst_q[rd_ptr_q];
        id_valid_d = 1'b1;
      end else if (bypass) begin
        id_pc_d    = addr_q;
        id_inst_d  = rom_data_i;
        id_valid_d = 1'b1;
      end else begin
        id_inst_d  = 32'h0;
        id_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      drop_q     <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      id_pc_q    <= 32'h0;
      id_inst_q  <= 32'h0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[wr_ptr_q]   <= addr_q;
      buf_inst_q[wr_ptr_q] <= rom_data_i;
    end
  end

  assign rom_ce_o   = (state_q == S_REQ);
  assign rom_addr_o = addr_q;
  assign id_pc_o    = id_pc_q;
  assign id_inst_o  = id_inst_q;
  assign id_valid_o = id_valid_q;

`ifdef IF_PERF_EN
  logic [31:0] perf_fetch_q, perf_bubble_q;
  logic        load_bubble;

  assign load_bubble = redirect_i || (!stall_i && !pop && !bypass);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q  <= 32'h0;
      perf_bubble_q <= 32'h0;
    end else begin
      if (ack_take)                perf_fetch_q  <= perf_fetch_q + 32'd1;
      if (!stall_i && load_bubble) perf_bubble_q <= perf_bubble_q + 32'd1;
    end
  end

  assign perf_fetch_o  = perf_fetch_q;
  assign perf_bubble_o = perf_bubble_q;
`endif
endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - self-checking bench for if_fetch
module tb_if_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic        rom_ack_i;
  logic [31:0] rom_data_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
`ifdef IF_PERF_EN
  logic [31:0] perf_fetch_o, perf_bubble_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [1:0] fixed_wait = 2'd0;
  logic [1:0] rnd_wait = 2'd0;
  logic       rand_waits = 1'b0;
  logic [2:0] wait_cnt = 3'd0;
  logic [1:0] eff_wait;

  if_fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .rom_ce_o(rom_ce_o), .rom_addr_o(rom_addr_o),
    .rom_ack_i(rom_ack_i), .rom_data_i(rom_data_i), .id_pc_o(id_pc_o),
    .id_inst_o(id_inst_o), .id_valid_o(id_valid_o)
`ifdef IF_PERF_EN
    , .perf_fetch_o(perf_fetch_o), .perf_bubble_o(perf_bubble_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // ROM model: ack after eff_wait wait cycles, data is a fixed function of the address
  assign eff_wait   = rand_waits ? rnd_wait : fixed_wait;
  assign rom_ack_i  = rom_ce_o && (wait_cnt >= 3'(eff_wait));
  assign rom_data_i = rom_fn(rom_addr_o);

  always @(posedge clk) begin
    if (rst || !rom_ce_o || rom_ack_i) wait_cnt <= 3'd0;
    else                               wait_cnt <= wait_cnt + 3'd1;
    if (rom_ce_o && rom_ack_i) rnd_wait <= 2'($urandom_range(0, 2));
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic r, input logic [31:0] rpc);
    stall_i = s;
    redirect_i = r;
    redirect_pc_i = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        s;
    logic        r;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic        ece;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc, input logic ece);
    vec_t v;
    v.s = s; v.r = r; v.rpc = rpc; v.ev = ev; v.epc = epc; v.ece = ece;
    return v;
  endfunction

  logic        s_r, r_r, found;
  logic [31:0] rpc_r, exp_pc, prev_pc, prev_inst, prev_addr;
  logic        prev_valid, prev_ce, prev_ack;
  int          idle;

  initial begin
    // zero-wait ROM trace: stall window, redirect to wrap region, misaligned redirect, stall+redirect
    tbl[0] = mk(0, 0, 0, 0, 32'h0, 1);
    for (int k = 1; k <= 4; k++) tbl[k] = mk(0, 0, 0, 1, 32'((k - 1) * 4), 1);
    tbl[5] = mk(1, 0, 0, 1, 32'hC, 1);
    for (int k = 6; k <= 9; k++) tbl[k] = mk(1, 0, 0, 1, 32'hC, 0);
    for (int k = 10; k <= 13; k++) tbl[k] = mk(0, 0, 0, 1, 32'(16 + (k - 10) * 4), 1);
    tbl[14] = mk(0, 1, 32'hFFFF_FFF8, 0, 32'h1C, 1);
    tbl[15] = mk(0, 0, 0, 1, 32'hFFFF_FFF8, 1);
    tbl[16] = mk(0, 0, 0, 1, 32'hFFFF_FFFC, 1);
    tbl[17] = mk(0, 0, 0, 1, 32'h0, 1);
    tbl[18] = mk(0, 0, 0, 1, 32'h4, 1);
    tbl[19] = mk(0, 1, 32'h103, 0, 32'h4, 1);
    tbl[20] = mk(0, 0, 0, 1, 32'h100, 1);
    tbl[21] = mk(0, 0, 0, 1, 32'h104, 1);
    tbl[22] = mk(1, 1, 32'h200, 0, 32'h104, 1);
    tbl[23] = mk(0, 0, 0, 1, 32'h200, 1);
    tbl[24] = mk(0, 0, 0, 1, 32'h204, 1);

    fixed_wait = 2'd0;
    do_reset();
    chk("reset_ce", rom_ce_o, 0);
    chk("reset_addr", rom_addr_o, RESET_PC);
    chk("reset_id_pc", id_pc_o, 0);
    chk("reset_id_inst", id_inst_o, 0);
    chk("reset_id_valid", id_valid_o, 0);

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].s, tbl[i].r, tbl[i].rpc);
      chk($sformatf("tbl%0d_valid", i), id_valid_o, tbl[i].ev);
      chk($sformatf("tbl%0d_pc", i), id_pc_o, tbl[i].epc);
      chk($sformatf("tbl%0d_inst", i), id_inst_o, tbl[i].ev ? rom_fn(tbl[i].epc) : 32'h0);
      chk($sformatf("tbl%0d_ce", i), rom_ce_o, tbl[i].ece);
    end

    // two wait cycles: address held 3 cycles, valid pattern 1,0,0
    fixed_wait = 2'd2;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 0);
      if (k <= 3) begin
        chk($sformatf("wait_addr_hold%0d", k), rom_addr_o, 32'h0);
        chk($sformatf("wait_ce%0d", k), rom_ce_o, 1);
      end else begin
        chk($sformatf("wait_valid%0d", k), id_valid_o, ((k - 4) % 3) == 0);
        if (((k - 4) % 3) == 0) chk($sformatf("wait_pc%0d", k), id_pc_o, 32'((k - 4) / 3 * 4));
      end
    end

    // redirect while a wait-state request is outstanding: stale response dropped
    do_reset();
    step(0, 0, 0);
    step(0, 1, 32'h100);
    chk("drop_valid", id_valid_o, 0);
    chk("drop_ce_held", rom_ce_o, 1);
    chk("drop_addr_held", rom_addr_o, 32'h0);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      step(0, 0, 0);
      if (id_valid_o) begin
        found = 1'b1;
        chk("drop_first_pc", id_pc_o, 32'h100);
        chk("drop_first_inst", id_inst_o, rom_fn(32'h100));
      end
    end
    chk("drop_found", found, 1);

    // reset asserted while the ROM acks: response ignored, fetch restarts at RESET_PC
    do_reset();
    repeat (3) step(0, 0, 0);
    chk("mid_rst_ack_pending", rom_ack_i, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_ce", rom_ce_o, 0);
    chk("mid_rst_addr", rom_addr_o, RESET_PC);
    chk("mid_rst_valid", id_valid_o, 0);
    chk("mid_rst_pc", id_pc_o, 0);
    rst = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      step(0, 0, 0);
      if (id_valid_o) begin
        found = 1'b1;
        chk("mid_rst_first_pc", id_pc_o, RESET_PC);
      end
    end
    chk("mid_rst_found", found, 1);

    // random stalls, redirects and ROM wait states against an in-order PC stream model
    rand_waits = 1'b1;
    do_reset();
    exp_pc = RESET_PC;
    idle = 0;
    for (int n = 0; n < 600; n++) begin
      s_r = ($urandom_range(0, 99) < 30);
      r_r = ($urandom_range(0, 99) < 6);
      rpc_r = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      prev_pc = id_pc_o;
      prev_inst = id_inst_o;
      prev_valid = id_valid_o;
      prev_ce = rom_ce_o;
      prev_ack = rom_ack_i;
      prev_addr = rom_addr_o;
      step(s_r, r_r, rpc_r);
      if (prev_ce && !prev_ack) begin
        chk("rnd_ce_held", rom_ce_o, 1);
        chk("rnd_addr_held", rom_addr_o, prev_addr);
      end
      if (r_r) begin
        chk("rnd_redir_valid", id_valid_o, 0);
        chk("rnd_redir_pc", id_pc_o, prev_pc);
        exp_pc = rpc_r & ~32'h3;
        idle = 0;
      end else if (s_r) begin
        chk("rnd_stall_pc", id_pc_o, prev_pc);
        chk("rnd_stall_inst", id_inst_o, prev_inst);
        chk("rnd_stall_valid", id_valid_o, prev_valid);
      end else if (id_valid_o) begin
        chk("rnd_pc", id_pc_o, exp_pc);
        chk("rnd_inst", id_inst_o, rom_fn(exp_pc));
        exp_pc = exp_pc + 32'd4;
        idle = 0;
      end else begin
        idle++;
        chk("rnd_bubble_inst", id_inst_o, 0);
        chk("rnd_bubble_pc", id_pc_o, prev_pc);
        chk("rnd_liveness", idle > 12, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
